// File: rtl/seal_gen.sv
`default_nettype none
// ============================================================================
// seal_gen : encrypts and tags plaintext bytes, then queues {plain, enc, tag}
//            triples for the integrity checker with valid/ready backpressure.
// Revision  : 1.0
// ============================================================================
module seal_gen #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               plain,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               plain_out,
  output logic [7:0]               enc_out,
  output logic [7:0]               hash_out,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         sealed_cnt
);

  localparam int              c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0]   c_FULL = (c_AW + 1)'(DEPTH);

  // Byte cipher: whiten with 0xA5, rotate left by 3, add 0x3C.
  function automatic logic [7:0] encrypt(input logic [7:0] p);
    logic [7:0] x;
    x = p ^ 8'hA5;
    return {x[4:0], x[7:5]} + 8'h3C;
  endfunction

  // Tag over the ciphertext: (29*e + 0x11) xor nibble-swapped e.
  function automatic logic [7:0] hash(input logic [7:0] e);
    logic [7:0] m;
    m = e * 8'd29;
    return (m + 8'h11) ^ {e[3:0], e[7:4]};
  endfunction

  logic              r_s1_valid;
  logic [7:0]        r_s1_plain;
  logic [7:0]        w_s1_enc;
  logic [7:0]        w_s1_h;
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_AW:0]     r_level;
  logic [CNT_W-1:0]  r_cnt;
  logic [23:0]       r_mem [DEPTH];
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_accept;

  assign w_s1_enc  = encrypt(r_s1_plain);
  assign w_s1_h    = hash(w_s1_enc);

  assign w_full    = (r_level == c_FULL);
  assign out_valid = (r_level != '0);
  assign w_pop     = out_valid & out_ready;
  assign w_push    = r_s1_valid & (~w_full | w_pop);
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign in_ready  = ~rst & (~r_s1_valid | w_push);
  assign w_accept  = in_valid & in_ready;

  assign {plain_out, enc_out, hash_out} = r_mem[r_rd_ptr];
  assign fifo_level = r_level;
  assign sealed_cnt = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_plain <= 8'h00;
    end else if (w_accept) begin
      r_s1_plain <= plain;
      r_s1_valid <= 1'b1;
    end else if (w_push) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 24'h000000;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {r_s1_plain, w_s1_enc, w_s1_h};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_cnt    <= r_cnt + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seal_gen.sv
`default_nettype none
// ============================================================================
// tb_seal_gen : randomized self-checking bench for seal_gen against a
//               queue-based reference model.
// Revision    : 1.0
// ============================================================================
module tb_seal_gen;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [7:0]        plain = 8'h00;
  logic              in_ready;
  logic              out_valid;
  logic [7:0]        plain_out;
  logic [7:0]        enc_out;
  logic [7:0]        hash_out;
  logic [2:0]        fifo_level;
  logic [CNT_W-1:0]  sealed_cnt;

  seal_gen #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plain      (plain),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plain_out  (plain_out),
    .enc_out    (enc_out),
    .hash_out   (hash_out),
    .fifo_level (fifo_level),
    .sealed_cnt (sealed_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: optional stage byte plus a queue of plaintexts.
  bit         m_s1v = 1'b0;
  logic [7:0] m_s1  = 8'h00;
  logic [7:0] m_q[$];
  int         m_cnt = 0;
  bit         m_pop, m_push, m_acc;

  function automatic logic [7:0] ref_enc(input logic [7:0] p);
    int x;
    x = int'(p) ^ 'hA5;
    return 8'((((x << 3) | (x >> 5)) + 'h3C) & 'hFF);
  endfunction

  function automatic logic [7:0] ref_hash(input logic [7:0] e);
    int v;
    v = int'(e);
    return 8'(((v * 29 + 'h11) & 'hFF) ^ (((v << 4) | (v >> 4)) & 'hFF));
  endfunction

  function automatic bit model_in_ready();
    return !rst && (!m_s1v || m_q.size() < DEPTH || (m_q.size() > 0 && out_ready));
  endfunction

  always @(posedge rst) begin
    m_s1v = 1'b0;
    m_q.delete();
    m_cnt = 0;
  end

  always @(posedge clk) begin
    if (!rst) begin
      m_pop  = (m_q.size() > 0) && out_ready;
      m_push = m_s1v && (m_q.size() < DEPTH || m_pop);
      m_acc  = in_valid && (!m_s1v || m_push);
      if (m_pop) begin
        void'(m_q.pop_front());
        m_cnt++;
      end
      if (m_push) m_q.push_back(m_s1);
      if (m_acc) begin
        m_s1  = plain;
        m_s1v = 1'b1;
      end else if (m_push) begin
        m_s1v = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    checks++; if (sealed_cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", sealed_cnt); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if ({plain_out, enc_out, hash_out} !== 24'h0) begin failures++; $display("FAIL reset_data got=%h exp=000000", {plain_out, enc_out, hash_out}); end
  endtask

  task automatic test_single();
    do_reset();
    in_valid = 1'b1; plain = 8'h41; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1; in_valid = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", out_valid); end
    @(posedge clk); #2;
    checks++; if ({out_valid, fifo_level} !== {1'b1, 3'd1}) begin failures++; $display("FAIL single_valid_level got=%b/%0d exp=1/1", out_valid, fifo_level); end
    checks++; if ({plain_out, enc_out, hash_out} !== {8'h41, ref_enc(8'h41), ref_hash(ref_enc(8'h41))}) begin
      failures++; $display("FAIL single_data got=%h exp=%h", {plain_out, enc_out, hash_out}, {8'h41, ref_enc(8'h41), ref_hash(ref_enc(8'h41))});
    end
    out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0; #1;
    checks++; if ({out_valid, sealed_cnt} !== {1'b0, 16'd1}) begin failures++; $display("FAIL single_pop got=%b/%0d exp=0/1", out_valid, sealed_cnt); end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int cyc = 0;
    bit acc;
    logic [7:0] got[$];
    bit bad = 1'b0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      in_valid = (idx < 8); plain = 8'(idx); #1;
      acc = in_valid && model_in_ready();
      @(posedge clk); #1;
      if (acc) idx++;
    end
    #1;
    checks++; if (idx != 5) begin failures++; $display("FAIL bp_accepted got=%0d exp=5", idx); end
    checks++; if ({in_ready, fifo_level} !== {1'b0, 3'd4}) begin failures++; $display("FAIL bp_full got=%b/%0d exp=0/4", in_ready, fifo_level); end
    #1; out_ready = 1'b1;
    while ((idx < 8 || m_s1v || m_q.size() > 0) && cyc < 40) begin
      in_valid = (idx < 8); plain = 8'(idx); #1;
      checks++; if ({in_ready, out_valid, fifo_level} !== {model_in_ready(), m_q.size() > 0, 3'(m_q.size())}) begin
        failures++; $display("FAIL bp_ctrl got=%b exp=%b", {in_ready, out_valid, fifo_level}, {model_in_ready(), m_q.size() > 0, 3'(m_q.size())});
      end
      if (m_q.size() > 0) got.push_back(plain_out);
      acc = in_valid && model_in_ready();
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    out_ready = 1'b0; in_valid = 1'b0;
    checks++; if (cyc >= 40) begin failures++; $display("FAIL bp_timeout got=%0d exp=<40", cyc); end
    if (got.size() != 8) bad = 1'b1;
    else for (int i = 0; i < 8; i++) if (got[i] !== 8'(i)) bad = 1'b1;
    checks++; if (bad) begin failures++; $display("FAIL bp_order got=%p exp=0..7", got); end
  endtask

  task automatic test_full_pop_push();
    logic [7:0] src[5];
    logic [7:0] got[$];
    int idx = 0;
    int cyc = 0;
    bit acc;
    bit bad = 1'b0;
    src[0] = 8'h10; src[1] = 8'h11; src[2] = 8'h12; src[3] = 8'h13; src[4] = 8'h55;
    do_reset();
    while (idx < 5 && cyc < 12) begin
      in_valid = 1'b1; plain = src[idx]; #1;
      acc = model_in_ready();
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0; #1;
    checks++; if ({in_ready, fifo_level} !== {1'b0, 3'd4}) begin failures++; $display("FAIL fpp_full got=%b/%0d exp=0/4", in_ready, fifo_level); end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fpp_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1; out_ready = 1'b0; #1;
    checks++; if ({fifo_level, plain_out} !== {3'd4, 8'h11}) begin failures++; $display("FAIL fpp_level_head got=%0d/%h exp=4/11", fifo_level, plain_out); end
    got.push_back(8'h10);
    out_ready = 1'b1; cyc = 0;
    while (m_q.size() > 0 && cyc < 20) begin
      #1;
      got.push_back(plain_out);
      checks++; if ({enc_out, hash_out} !== {ref_enc(m_q[0]), ref_hash(ref_enc(m_q[0]))}) begin
        failures++; $display("FAIL fpp_tag got=%h exp=%h", {enc_out, hash_out}, {ref_enc(m_q[0]), ref_hash(ref_enc(m_q[0]))});
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    if (got.size() != 5) bad = 1'b1;
    else for (int i = 0; i < 5; i++) if (got[i] !== src[i]) bad = 1'b1;
    checks++; if (bad) begin failures++; $display("FAIL fpp_order got=%p exp=10,11,12,13,55", got); end
  endtask

  task automatic test_streaming();
    int idx = 0;
    int edges = 0;
    do_reset();
    out_ready = 1'b1;
    while ((idx < 256 || m_s1v || m_q.size() > 0) && edges < 400) begin
      in_valid = (idx < 256); plain = 8'(idx); #1;
      if (idx < 256) begin
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready got=%b exp=1 idx=%0d", in_ready, idx); end
      end
      if (m_q.size() > 0) begin
        checks++; if ({out_valid, plain_out, enc_out, hash_out} !== {1'b1, m_q[0], ref_enc(m_q[0]), ref_hash(ref_enc(m_q[0]))}) begin
          failures++; $display("FAIL stream_data got=%h exp=%h", {out_valid, plain_out, enc_out, hash_out}, {1'b1, m_q[0], ref_enc(m_q[0]), ref_hash(ref_enc(m_q[0]))});
        end
      end
      @(posedge clk); #1;
      if (idx < 256) idx++;
      edges++;
    end
    in_valid = 1'b0; out_ready = 1'b0; #1;
    checks++; if (edges != 258) begin failures++; $display("FAIL stream_cycles got=%0d exp=258", edges); end
    checks++; if (sealed_cnt !== 16'd256) begin failures++; $display("FAIL stream_cnt got=%0d exp=256", sealed_cnt); end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; plain = 8'hA0 + 8'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (fifo_level !== 3'd3) begin failures++; $display("FAIL mid_pre_level got=%0d exp=3", fifo_level); end
    rst = 1'b1; #1;
    checks++; if ({out_valid, fifo_level, sealed_cnt, in_ready} !== {1'b0, 3'd0, 16'd0, 1'b0}) begin
      failures++; $display("FAIL mid_ctrl got=%b/%0d/%0d/%b exp=0/0/0/0", out_valid, fifo_level, sealed_cnt, in_ready);
    end
    checks++; if ({plain_out, enc_out, hash_out} !== 24'h0) begin failures++; $display("FAIL mid_data got=%h exp=000000", {plain_out, enc_out, hash_out}); end
    @(posedge clk); #1; rst = 1'b0;
    in_valid = 1'b1; plain = 8'h7E;
    @(posedge clk); #1; in_valid = 1'b0;
    while (!out_valid && cyc < 10) begin @(posedge clk); #1; cyc++; end
    checks++; if ({out_valid, plain_out, enc_out} !== {1'b1, 8'h7E, ref_enc(8'h7E)}) begin
      failures++; $display("FAIL mid_first got=%b/%h/%h exp=1/7e/%h", out_valid, plain_out, enc_out, ref_enc(8'h7E));
    end
  endtask

  task automatic test_loopback();
    int acc_n = 0;
    int popped = 0;
    int cyc = 0;
    bit acc;
    do_reset();
    while (popped < 1000 && cyc < 20000) begin
      in_valid  = (acc_n < 1000) && ($urandom_range(3) != 0);
      plain     = 8'($urandom);
      out_ready = ($urandom_range(4) < 3);
      #1;
      checks++; if ({in_ready, out_valid, fifo_level} !== {model_in_ready(), m_q.size() > 0, 3'(m_q.size())}) begin
        failures++; $display("FAIL loop_ctrl got=%b exp=%b cyc=%0d", {in_ready, out_valid, fifo_level}, {model_in_ready(), m_q.size() > 0, 3'(m_q.size())}, cyc);
      end
      if (m_q.size() > 0 && out_ready) begin
        checks++; if (plain_out !== m_q[0]) begin failures++; $display("FAIL loop_plain got=%h exp=%h", plain_out, m_q[0]); end
        checks++; if (enc_out !== ref_enc(plain_out)) begin failures++; $display("FAIL loop_enc_match got=%h exp=%h", enc_out, ref_enc(plain_out)); end
        checks++; if (hash_out !== ref_hash(enc_out)) begin failures++; $display("FAIL loop_hash_match got=%h exp=%h", hash_out, ref_hash(enc_out)); end
        popped++;
      end
      acc = in_valid && model_in_ready();
      @(posedge clk); #1;
      if (acc) acc_n++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0; #1;
    checks++; if (popped != 1000) begin failures++; $display("FAIL loop_timeout got=%0d exp=1000", popped); end
    checks++; if (sealed_cnt !== CNT_W'(m_cnt)) begin failures++; $display("FAIL loop_cnt got=%0d exp=%0d", sealed_cnt, m_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_full_pop_push();
    test_streaming();
    test_reset_mid();
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seal_gen.md
Name: seal_gen

Overview:
- Transmit-side counterpart of the integrity checker.
- Accepts plaintext bytes over a valid/ready handshake and encrypts each one with the codebase `encrypt` block.
- Computes the tag for each ciphertext with the codebase `hash` block, then queues the {plain, enc, hash} triple in an output FIFO.
- The FIFO drives the checker-side interface (plain, enc_in, ref_hash) with backpressure and counts sealed bytes.

Parameters:
- DEPTH, 4, output FIFO entries; power of two, ≥2.
- CNT_W, 16, width of sealed_cnt.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  plain is valid.
- in_ready  output  1  block accepts plain this cycle.
- plain  input  8  plaintext byte.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer takes the head this cycle.
- plain_out  output  8  plaintext of the head entry.
- enc_out  output  8  ciphertext of the head entry, equal to encrypt(plain_out).
- hash_out  output  8  tag of the head entry, equal to hash(enc_out).
- fifo_level  output  $clog2(DEPTH)+1  number of occupied FIFO entries.
- sealed_cnt  output  CNT_W  count of entries popped since reset.

Behaviour:
- Reset (rst=1, asynchronous):
  - s1_valid=0, FIFO pointers=0, fifo_level=0, out_valid=0, sealed_cnt=0.
  - FIFO storage is cleared, so plain_out, enc_out and hash_out read 0x00.
  - in_ready=0 while rst is high.
  - Reset mid-operation discards the stage-1 byte and all FIFO contents; no partial entry survives.
- Stage 1 (accept):
  - accept = in_valid & in_ready; on accept, s1_plain<=plain and s1_valid<=1.
  - in_ready = !rst & (!s1_valid | push).
  - in_ready therefore depends combinationally on out_ready, through push.
- Compute:
  - encrypt(s1_plain) -> s1_enc, and hash(s1_enc) -> s1_h, both combinational from the stage-1 register.
  - The hash input is the ciphertext, never the plaintext.
- Stage 2 (FIFO push):
  - push = s1_valid & (!full | pop).
  - On push, {s1_plain, s1_enc, s1_h} is written at wr_ptr and wr_ptr advances.
  - If push occurs without a new accept in the same cycle, s1_valid<=0.
  - If push and accept occur in the same cycle, s1 is reloaded and s1_valid stays 1.
- FIFO pop:
  - pop = out_valid & out_ready; out_valid = (fifo_level != 0).
  - Outputs are combinational reads at rd_ptr; they are stable while out_valid=1 and out_ready=0.
  - When empty, the outputs hold stale data; consumers sample only when out_valid=1.
- Full/empty corner cases:
  - Full with pop in the same cycle: push is allowed, level is unchanged, no stall.
  - Full without pop: push is blocked, s1 holds, in_ready=0.
  - Empty: pop is impossible; a push and a would-be pop in the same cycle cannot happen because out_valid=0.
- Pointers and level:
  - Pointers wrap modulo DEPTH.
  - fifo_level changes by +1 on push only, −1 on pop only, 0 on both.
- Latency: a byte accepted at edge N is pushed at edge N+1. out_valid rises after edge N+1 if the FIFO was empty, giving a minimum latency of 2 cycles.
- Throughput: 1 byte/cycle sustained when out_ready=1.
- sealed_cnt increments by 1 on each pop and wraps from 2^CNT_W−1 to 0.
- Ordering: strict FIFO, with no drops and no duplicates.
- Compatibility: on every popped entry, feeding {plain_out, enc_out, hash_out} into the checker as {plain, enc_in, ref_hash} must yield a match result of 1.

Test Plan:
- Reset then single byte: release rst, plain=0x41 with one-cycle in_valid → out_valid rises 2 cycles later. plain_out=0x41, enc_out=encrypt(0x41), hash_out=hash(enc_out), fifo_level=1. Pulse out_ready → sealed_cnt=1, out_valid=0.
- Backpressure fill: out_ready=0, stream 0x00..0x07 → accepts DEPTH+1=5 bytes (4 in FIFO, 1 in s1), then in_ready=0 and fifo_level=4. Raise out_ready → entries pop in order 0x00..0x04; the stream resumes with no loss.
- Full with simultaneous pop/push: FIFO full, s1 holding 0x55, out_ready=1 → push and pop in the same cycle, fifo_level stays 4, in_ready=1 that cycle, and 0x55 later exits in order.
- Streaming: out_ready=1, 256 bytes 0x00..0xFF back-to-back → one output per cycle after a 2-cycle fill, matching a reference model (encrypt/hash). sealed_cnt=256 at the end (with CNT_W=8 parameterised it wraps to 0).
- Reset mid-stream: assert rst asynchronously (between edges) with fifo_level=3 → out_valid, fifo_level, sealed_cnt and outputs go to 0 immediately, in_ready=0. After release, a new byte 0x7E is the first output.
- Loopback: connect outputs to the checker, random plaintext and random out_ready for 1000 bytes → the checker's enc_match, hash_match and valid_flag are 1 for every popped entry.
